// File: rtl/crc8_pkg.sv
// Purpose: shared constants, FSM state type and CRC-8 table-entry function for the frame checker.
// Latency: n/a (package).
// Backpressure: n/a (package).
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
    localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // One table entry: the CRC register after shifting eight zero bits
    // through a register preloaded with idx (MSB-first, non-reflected).
    function automatic logic [7:0] crc8_table_entry(input logic [7:0] poly,
                                                    input logic [7:0] idx);
        logic [7:0] c;
        c = idx;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ poly;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_table.sv
// Purpose: 256-entry CRC-8 lookup ROM for a fixed generator polynomial.
// Latency: 1 cycle, registered read (data_o reflects addr_i of the previous cycle).
// Backpressure: none, reads every cycle.
//
// Ports: clk_i/rst_ni clock and async active-low reset; addr_i table index;
//        data_o registered table entry.
module crc_table
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] addr_i,
    output logic [7:0] data_o
);

    // Entry is a constant function of the address, so this folds to a ROM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) data_o <= 8'h00;
        else         data_o <= crc8_table_entry(POLYNOMIAL, addr_i);
    end

endmodule

// File: rtl/crc8_frame_checker.sv
// Purpose: checks the trailing CRC-8 of each byte frame, forwards the payload with the CRC stripped.
// Latency: payload byte leaves on the accept of the following byte; status 2 cycles after the CRC accept.
// Backpressure: s_ready_o drops while the output register is full and not draining; status ignores m_ready_i.
//
// Ports: s_data_i/s_valid_i/s_last_i/s_ready_o input byte stream (s_last_i marks the CRC byte);
//        m_data_o/m_valid_o/m_last_o/m_ready_i payload stream (m_last_o on the final payload byte);
//        done_o one-cycle status pulse, crc_ok_o residue-zero flag, crc_o residue (held until next done_o).
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = CRC8_POLY_DEFAULT,
    parameter logic [7:0] INIT       = CRC8_INIT_DEFAULT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    input  logic       s_last_i,
    output logic       s_ready_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    output logic       m_last_o,
    input  logic       m_ready_i,
    output logic       done_o,
    output logic       crc_ok_o,
    output logic [7:0] crc_o
);

    state_t     state_q, state_d;
    logic [7:0] crc_q;
    logic       last_q;
    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic [7:0] crc_hold_q;
    logic       run_q;
    logic [7:0] rom_addr;
    logic [7:0] rom_dat;
    logic       accept;
    logic       out_drain;

    crc_table #(
        .POLYNOMIAL (POLYNOMIAL)
    ) u_crc_table (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .addr_i (rom_addr),
        .data_o (rom_dat)
    );

    // run_q keeps s_ready_o low while in reset and for the first cycle out of it.
    assign s_ready_o = run_q && (state_q == S_IDLE) && (!m_valid_o || m_ready_i);
    assign accept    = s_valid_i && s_ready_o;
    assign out_drain = m_valid_o && m_ready_i;

    // crc_q is stable while in S_IDLE, so the ROM sees the accept-cycle
    // address and presents the next CRC value in S_UPDATE.
    assign rom_addr  = crc_q ^ s_data_i;

    assign done_o    = (state_q == S_DONE);
    assign crc_ok_o  = (state_q == S_DONE) && (crc_q == 8'h00);
    assign crc_o     = (state_q == S_DONE) ? crc_q : crc_hold_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_UPDATE;
            S_UPDATE: state_d = last_q ? S_DONE : S_IDLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            crc_q      <= INIT;
            last_q     <= 1'b0;
            crc_hold_q <= 8'h00;
            run_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (accept) last_q <= s_last_i;
            if (state_q == S_UPDATE) crc_q <= rom_dat;
            if (state_q == S_DONE) begin
                crc_q      <= INIT;
                crc_hold_q <= crc_q;
            end
        end
    end

    // One-byte delay line: a byte is only known to be payload once the next
    // beat arrives, and the beat that carries s_last_i is the CRC itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q       <= 8'h00;
            hold_valid_q <= 1'b0;
        end else if (accept) begin
            if (s_last_i) begin
                hold_valid_q <= 1'b0;
            end else begin
                hold_q       <= s_data_i;
                hold_valid_q <= 1'b1;
            end
        end
    end

    // Output register; a load in the drain cycle overrides the clear, so a
    // simultaneous handshake and accept costs no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_data_o  <= 8'h00;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end else if (accept && hold_valid_q) begin
            m_data_o  <= hold_q;
            m_last_o  <= s_last_i;
            m_valid_o <= 1'b1;
        end else if (out_drain) begin
            m_data_o  <= 8'h00;
            m_last_o  <= 1'b0;
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Purpose: scoreboard bench for crc8_frame_checker (payload beats and per-frame status).
// Latency: n/a.
// Backpressure: optional random m_ready_i stalls.
module tb_crc8_frame_checker;
    import crc8_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] s_data_i = 8'h00;
    logic       s_valid_i = 1'b0;
    logic       s_last_i = 1'b0;
    logic       s_ready_o;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_last_o;
    logic       m_ready_i = 1'b0;
    logic       done_o;
    logic       crc_ok_o;
    logic [7:0] crc_o;

    crc8_frame_checker #(
        .POLYNOMIAL (8'h07),
        .INIT       (8'h00)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .s_data_i  (s_data_i),
        .s_valid_i (s_valid_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .m_ready_i (m_ready_i),
        .done_o    (done_o),
        .crc_ok_o  (crc_ok_o),
        .crc_o     (crc_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [8:0] exp_beats[$];   // {last, data}
    logic [8:0] exp_stat[$];    // {ok, residue}
    logic [7:0] frm[$];

    bit         mon_en     = 1'b0;
    bit         abort_ph   = 1'b0;
    bit         stall_mode = 1'b0;
    bit         finished   = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_dat   = 8'h00;
    logic       prev_last  = 1'b0;
    logic [7:0] last_crc   = 8'h00;
    logic       rdy_rec[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit-serial reference CRC-8, MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++)
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            m_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && mon_en) begin
                if (prev_stall) begin
                    check("stall_valid", m_valid_o, 1);
                    check("stall_data",  m_data_o,  prev_dat);
                    check("stall_last",  m_last_o,  prev_last);
                end
                if (abort_ph) begin
                    check("abort_no_done", done_o, 0);
                end else begin
                    if (m_valid_o && m_ready_i) begin
                        if (exp_beats.size() == 0) begin
                            check("beat_unexpected", m_valid_o, 0);
                        end else begin
                            logic [8:0] e;
                            e = exp_beats.pop_front();
                            check("beat_data", m_data_o, e[7:0]);
                            check("beat_last", m_last_o, e[8]);
                        end
                    end
                    if (done_o) begin
                        done_cnt++;
                        if (exp_stat.size() == 0) begin
                            check("stat_unexpected", done_o, 0);
                        end else begin
                            logic [8:0] e;
                            e = exp_stat.pop_front();
                            check("stat_ok",  crc_ok_o, e[8]);
                            check("stat_crc", crc_o,    e[7:0]);
                            last_crc = e[7:0];
                        end
                    end else begin
                        check("crc_held", crc_o, last_crc);
                        check("ok_low",   crc_ok_o, 0);
                    end
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_dat   = m_data_o;
                prev_last  = m_last_o;
            end
        end
    end

    task automatic reset_chk(input string tag);
        @(negedge clk_i);
        check({tag, "_m_valid"}, m_valid_o, 0);
        check({tag, "_m_last"},  m_last_o,  0);
        check({tag, "_m_data"},  m_data_o,  0);
        check({tag, "_done"},    done_o,    0);
        check({tag, "_crc_ok"},  crc_ok_o,  0);
        check({tag, "_crc"},     crc_o,     0);
        check({tag, "_s_ready"}, s_ready_o, 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        logic acc;
        int   guard;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        guard     = 0;
        acc       = 1'b0;
        do begin
            @(negedge clk_i);
            acc = s_ready_o;
            @(posedge clk_i);
            #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) check("accept_timeout", acc, 1);
    endtask

    // Sends frm (payload followed by CRC byte) and pushes its expectations.
    task automatic send_frame(input bit drop_valid);
        logic [7:0] c;
        int         n;
        n = frm.size();
        c = 8'h00;
        for (int i = 0; i < n; i++) c = ref_crc(c, frm[i]);
        exp_stat.push_back({(c == 8'h00), c});
        for (int i = 0; i < n - 1; i++) exp_beats.push_back({(i == n - 2), frm[i]});
        for (int i = 0; i < n; i++) send_byte(frm[i], (i == n - 1));
        if (drop_valid) s_valid_i = 1'b0;
    endtask

    task automatic load_check_frame(input logic [7:0] crc_byte);
        frm.delete();
        for (int i = 0; i < 9; i++) frm.push_back(8'h31 + 8'(i));
        frm.push_back(crc_byte);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while ((exp_beats.size() != 0 || exp_stat.size() != 0) && guard < 2000) begin
            @(negedge clk_i);
            guard++;
        end
        check({tag, "_drain_timeout"}, (exp_beats.size() == 0 && exp_stat.size() == 0), 1);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (20000) @(posedge clk_i);
        check("watchdog_timeout", finished, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        reset_chk("rst");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // "123456789" with correct CRC 0xF4
        load_check_frame(8'hF4);
        send_frame(1);
        drain("good");

        // Same payload, CRC byte off by one
        load_check_frame(8'hF5);
        send_frame(1);
        drain("bad");

        // CRC-only frame
        frm.delete();
        frm.push_back(8'h00);
        send_frame(1);
        drain("single");

        // Back-to-back frames with s_valid_i held high
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_i);
                    rdy_rec[i] = s_ready_o;
                end
            end
            begin
                frm.delete();
                frm.push_back(8'h01);
                frm.push_back(8'h07);
                send_frame(0);
                frm.delete();
                frm.push_back(8'h02);
                frm.push_back(8'h0E);
                send_frame(1);
            end
        join
        begin
            logic [9:0] rdy_exp;
            rdy_exp = 10'b1010010100;
            for (int i = 0; i < 10; i++) check($sformatf("b2b_s_ready[%0d]", i), rdy_rec[i], rdy_exp[9 - i]);
        end
        drain("b2b");

        // Random frames under random downstream stalls
        stall_mode = 1'b1;
        for (int f = 0; f < 200; f++) begin
            logic [7:0] c;
            int         len;
            frm.delete();
            len = $urandom_range(0, 7);
            c   = 8'h00;
            for (int i = 0; i < len; i++) begin
                frm.push_back(8'($urandom_range(0, 255)));
                c = ref_crc(c, frm[i]);
            end
            frm.push_back(c);
            send_frame($urandom_range(0, 1) == 1);
        end
        s_valid_i = 1'b0;
        drain("stall");
        stall_mode = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;

        // Reset in the middle of a frame
        abort_ph = 1'b1;
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        s_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        reset_chk("midrst");
        reset_chk("midrst2");
        abort_ph   = 1'b0;
        prev_stall = 1'b0;
        last_crc   = 8'h00;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        load_check_frame(8'hF4);
        send_frame(1);
        drain("post_rst");

        check("done_count", done_cnt, 206);
        finished = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
